// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default parameter
// values, the smallest legal divisor and divisor helper functions.
package clk_div_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DIV       = 80;
  localparam int DEF_ODD_EXACT = 1;

  localparam logic [31:0] DIV_MIN = 32'd2;

  // Divisors of 0 or 1 cannot produce a clock; they are raised to the minimum.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // Ceiling of n/2, written so that n = all-ones cannot overflow the width.
  function automatic logic [31:0] half_ceil(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_odd_fix.sv
// Odd-divisor duty correction: a negedge retime of out_pos ANDed with
// out_pos trims half a clock off the high time, giving exact 50% duty.
module clk_div_odd_fix
  import clk_div_pkg::*;
#(
  parameter int ODD_EXACT = DEF_ODD_EXACT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic out_pos,
  input  logic odd,
  output logic out
);

  logic out_neg;

  // Half-cycle delayed copy of out_pos; cleared while disabled so out falls cleanly.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      out_neg <= 1'b0;
    end else if (!en) begin
      out_neg <= 1'b0;
    end else begin
      out_neg <= out_pos;
    end
  end

  assign out = ((ODD_EXACT != 0) && odd) ? (out_pos & out_neg) : out_pos;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider. A new divisor is held pending
// and only takes effect at a period boundary (or immediately while disabled),
// so the output never produces a runt pulse.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int ODD_EXACT   = DEF_ODD_EXACT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_cur,
  output logic             out,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pending;
  logic             pend_v;
  logic             running;
  logic             at_wrap;
  logic             boundary;
  logic             apply;
  logic             out_pos;
  logic             out_pos_nxt;

  // Period bookkeeping: next count value and whether this posedge starts a period.
  // A stopped divider (after reset or while disabled) starts a fresh period at k=0.
  always_comb begin
    load_val    = WIDTH'(clamp_div(32'(div_in)));
    half        = WIDTH'(half_ceil(32'(div_cur)));
    at_wrap     = running && (count == div_cur - WIDTH'(1));
    boundary    = !running || at_wrap;
    apply       = (pend_v || div_load) && (!en || boundary);
    count_nxt   = boundary ? '0 : count + WIDTH'(1);
    out_pos_nxt = (count_nxt < half);
  end

  // Divisor staging: capture loads into pending, commit at a boundary with an ack.
  // A load coinciding with the commit bypasses pending, so the newest value wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cur <= WIDTH'(DEFAULT_DIV);
      pending <= '0;
      pend_v  <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      if (apply) begin
        div_cur <= div_load ? load_val : pending;
        pend_v  <= 1'b0;
        div_ack <= 1'b1;
      end else if (div_load) begin
        pending <= load_val;
        pend_v  <= 1'b1;
      end
    end
  end

  // Counter and registered output phase; disabling parks everything at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      running <= 1'b0;
      out_pos <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      count   <= '0;
      running <= 1'b0;
      out_pos <= 1'b0;
      tick    <= 1'b0;
    end else begin
      count   <= count_nxt;
      running <= 1'b1;
      out_pos <= out_pos_nxt;
      tick    <= boundary;
    end
  end

  clk_div_odd_fix #(
    .ODD_EXACT(ODD_EXACT)
  ) u_odd_fix (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .out_pos(out_pos),
    .odd    (div_cur[0]),
    .out    (out)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios followed by random loads and
// enable drops. A period-level reference model predicts every cycle; a
// separate monitor samples the DUT and compares against the queued predictions.
module tb_clk_div_prog;

  localparam int W        = 8;
  localparam int DEF      = 80;
  localparam int ODD_EXCT = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_i;
  logic         load_i;
  logic [W-1:0] din_i;
  logic         div_ack;
  logic [W-1:0] div_cur;
  logic         out;
  logic         tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] cur;
    logic         ack;
    logic         tick;
    logic         o1;   // out during the high phase of clk
    logic         o2;   // out during the low phase of clk
  } exp_t;

  exp_t exp_q[$];

  clk_div_prog #(
    .WIDTH      (W),
    .DEFAULT_DIV(DEF),
    .ODD_EXACT  (ODD_EXCT)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .en      (en_i),
    .div_in  (din_i),
    .div_load(load_i),
    .div_ack (div_ack),
    .div_cur (div_cur),
    .out     (out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period (-1 = stopped), divisor in force,
  // and the last requested but not yet applied divisor (-1 = none).
  int   m_n    = DEF;
  int   m_k    = -1;
  int   m_pend = -1;
  logic m_pos  = 1'b0;
  logic m_prev = 1'b0;
  logic m_tick = 1'b0;
  logic m_ack  = 1'b0;

  // Predict one clock of DUT behaviour from the inputs seen at this posedge.
  always @(posedge clk) begin
    exp_t e;
    int   req;
    bit   period_start;
    m_prev = m_pos;
    if (!rst_n) begin
      m_n = DEF; m_k = -1; m_pend = -1;
      m_pos = 1'b0; m_prev = 1'b0; m_tick = 1'b0; m_ack = 1'b0;
    end else begin
      req = (int'(din_i) < 2) ? 2 : int'(din_i);
      period_start = (m_k < 0) || (m_k == m_n - 1);
      m_ack = 1'b0;
      if ((!en_i || period_start) && (load_i || m_pend >= 0)) begin
        m_n    = load_i ? req : m_pend;
        m_pend = -1;
        m_ack  = 1'b1;
      end else if (load_i) begin
        m_pend = req;
      end
      if (!en_i) begin
        m_k = -1; m_pos = 1'b0; m_tick = 1'b0;
      end else begin
        m_k    = period_start ? 0 : m_k + 1;
        m_pos  = (m_k < (m_n + 1) / 2);
        m_tick = (m_k == 0);
      end
    end
    e.cur  = W'(m_n);
    e.ack  = m_ack;
    e.tick = m_tick;
    e.o2   = m_pos;
    e.o1   = (ODD_EXCT != 0 && (m_n % 2) == 1) ? (m_pos & m_prev) : m_pos;
    exp_q.push_back(e);
  end

  // Monitor: sample both clock phases, then pop and compare one prediction.
  initial begin
    logic [W-1:0] s_cur;
    logic         s_ack, s_tick, s_o1, s_o2;
    exp_t         e;
    forever begin
      @(posedge clk); #1;
      s_cur = div_cur; s_ack = div_ack; s_tick = tick; s_o1 = out;
      @(negedge clk); #1;
      s_o2 = out;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: DUT produced a cycle with no prediction", $time);
      end else begin
        e = exp_q.pop_front();
        if (s_cur !== e.cur || s_ack !== e.ack || s_tick !== e.tick ||
            s_o1 !== e.o1 || s_o2 !== e.o2) begin
          errors++;
          if (errors <= 30)
            $display("FAIL cycle t=%0t: got cur=%0d ack=%b tick=%b out=%b/%b, want cur=%0d ack=%b tick=%b out=%b/%b",
                     $time, s_cur, s_ack, s_tick, s_o1, s_o2, e.cur, e.ack, e.tick, e.o1, e.o2);
        end
      end
    end
  end

  // Drive inputs just after the negedge so they are stable at the next posedge.
  task automatic step(input logic e, input logic ld, input logic [W-1:0] d);
    @(negedge clk); #2;
    en_i = e; load_i = ld; din_i = d;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b0, W'($urandom));
  endtask

  task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Assert reset mid-cycle and confirm the outputs fall without waiting for a clock.
  task automatic async_reset_check();
    @(negedge clk); #2;
    rst_n = 1'b0; load_i = 1'b0;
    #1;
    check1("async_out",     W'(out),     '0);
    check1("async_tick",    W'(tick),    '0);
    check1("async_ack",     W'(div_ack), '0);
    check1("async_div_cur", div_cur,     W'(DEF));
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    rst_n = 1'b1; en_i = 1'b1; load_i = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_div();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3)  return W'(255);
    if (r < 12) return W'($urandom_range(0, 1));
    return W'($urandom_range(2, 24));
  endfunction

  initial begin
    rst_n = 1'b0; en_i = 1'b0; load_i = 1'b0; din_i = '0;
    repeat (3) step(1'b0, 1'b0, '0);
    check1("reset_div_cur", div_cur, W'(DEF));
    check1("reset_out",     W'(out), '0);
    release_reset();

    // Default divisor, then a load of 9 partway into a period.
    run(180);
    step(1'b1, 1'b1, W'(9));
    run(120);
    // Two loads before the wrap: only the later one is applied, with one ack.
    step(1'b1, 1'b1, W'(80));
    run(90);
    step(1'b1, 1'b1, W'(12));
    run(20);
    step(1'b1, 1'b1, W'(9));
    run(100);
    // Clamp of 1 to 2, then the largest divisor, then even 12.
    step(1'b1, 1'b1, W'(1));
    run(30);
    step(1'b1, 1'b1, W'(0));
    run(10);
    step(1'b1, 1'b1, W'(255));
    run(560);
    step(1'b1, 1'b1, W'(12));
    run(300);
    // Back to 80, then drop enable early in a period and re-raise it.
    step(1'b1, 1'b1, W'(80));
    run(95);
    repeat (3) step(1'b0, 1'b0, '0);
    run(100);
    // Load while disabled is applied at once.
    step(1'b0, 1'b1, W'(7));
    step(1'b0, 1'b0, '0);
    run(40);
    // Reset with a divisor pending: it must be discarded.
    step(1'b1, 1'b1, W'(80));
    run(70);
    step(1'b1, 1'b1, W'(5));
    run(5);
    async_reset_check();
    repeat (2) @(negedge clk);
    release_reset();
    run(170);

    // Random loads and enable drops.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       step(1'b1, 1'b1, pick_div());
      else if (r < 6)  step(1'b0, 1'($urandom_range(0, 1)), pick_div());
      else             step(1'b1, 1'b0, W'($urandom));
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, want at most 1", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
